// File: rtl/risc_pkg.sv
// Shared definitions for the operand stage and its neighbours: select widths,
// status-flag bit positions and the execute-register control bundle.
package risc_pkg;

    localparam int unsigned GSEL_W = 4;
    localparam int unsigned HSEL_W = 2;

    // Widest supported destination address (up to 256 registers).
    localparam int unsigned DST_W = 8;

    localparam int unsigned STAT_C = 3;
    localparam int unsigned STAT_N = 2;
    localparam int unsigned STAT_V = 1;
    localparam int unsigned STAT_Z = 0;

    typedef struct packed {
        logic [GSEL_W-1:0] gsel;
        logic [HSEL_W-1:0] hsel;
        logic              mfsel;
        logic [DST_W-1:0]  dst;
        logic              wr;
        logic              ld_stat;
    } ex_ctrl_t;

endpackage

// File: rtl/regfile_2r1w.sv
// General-purpose register file: two asynchronous read ports, one synchronous
// write port, R0 hardwired to zero, asynchronous clear.
module regfile_2r1w #(
    parameter int unsigned BITS = 16,
    parameter int unsigned REGS = 8,
    localparam int unsigned AW  = $clog2(REGS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [AW-1:0]   ra_addr_i,
    output logic [BITS-1:0] ra_data_o,
    input  logic [AW-1:0]   rb_addr_i,
    output logic [BITS-1:0] rb_data_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [BITS-1:0] wdata_i
);

    logic [BITS-1:0] regs_q [REGS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
    assign rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/operand_stage.sv
// Operand fetch stage: register file read with write-back forwarding, the
// execute pipeline register feeding the function unit, and the status register.
module operand_stage
    import risc_pkg::*;
#(
    parameter int unsigned BITS = 16,
    parameter int unsigned REGS = 8,
    localparam int unsigned AW  = $clog2(REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_sa,
    input  logic [AW-1:0]     in_sb,
    input  logic [AW-1:0]     in_dst,
    input  logic              in_wr,
    input  logic              in_ld_stat,
    input  logic              in_mb,
    input  logic [BITS-1:0]   in_const,
    input  logic [GSEL_W-1:0] in_gsel,
    input  logic [HSEL_W-1:0] in_hsel,
    input  logic              in_mfsel,
    output logic [BITS-1:0]   A,
    output logic [BITS-1:0]   B,
    output logic [GSEL_W-1:0] GSel,
    output logic [HSEL_W-1:0] HSel,
    output logic              MFSel,
    output logic              ex_valid,
    input  logic              ex_ready,
    input  logic [BITS-1:0]   fu_out,
    input  logic              fu_c,
    input  logic              fu_n,
    input  logic              fu_v,
    input  logic              fu_z,
    output logic [3:0]        stat
);

    ex_ctrl_t        ex_q, ex_d;
    logic            ex_valid_q, ex_valid_d;
    logic [BITS-1:0] a_q, a_d;
    logic [BITS-1:0] b_q, b_d;
    logic [3:0]      stat_q, stat_d;

    logic            issue;
    logic            ex_fire;
    logic            rf_we;
    logic [BITS-1:0] rd_a, rd_b;
    logic            fwd_hit_a, fwd_hit_b;
    logic [BITS-1:0] fwd_a, fwd_b;

    assign in_ready = !ex_valid_q || ex_ready;
    assign issue    = in_valid && in_ready;
    assign ex_fire  = ex_valid_q && ex_ready;
    assign rf_we    = ex_fire && ex_q.wr;

    regfile_2r1w #(
        .BITS (BITS),
        .REGS (REGS)
    ) u_regfile (
        .clk_i     (clk),
        .rst_i     (rst),
        .ra_addr_i (in_sa),
        .ra_data_o (rd_a),
        .rb_addr_i (in_sb),
        .rb_data_o (rd_b),
        .we_i      (rf_we),
        .waddr_i   (ex_q.dst[AW-1:0]),
        .wdata_i   (fu_out)
    );

    // Bypass the result being written this edge so dependent issues never stall.
    // The zero-address test keeps a discarded R0 write from leaking through.
    assign fwd_hit_a = rf_we && (ex_q.dst == DST_W'(in_sa));
    assign fwd_hit_b = rf_we && (ex_q.dst == DST_W'(in_sb));
    assign fwd_a     = (in_sa == '0) ? '0 : (fwd_hit_a ? fu_out : rd_a);
    assign fwd_b     = (in_sb == '0) ? '0 : (fwd_hit_b ? fu_out : rd_b);

    always_comb begin
        ex_d       = ex_q;
        ex_valid_d = ex_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        stat_d     = stat_q;

        if (issue) begin
            ex_valid_d    = 1'b1;
            a_d           = fwd_a;
            b_d           = in_mb ? in_const : fwd_b;
            ex_d.gsel     = in_gsel;
            ex_d.hsel     = in_hsel;
            ex_d.mfsel    = in_mfsel;
            ex_d.dst      = DST_W'(in_dst);
            ex_d.wr       = in_wr;
            ex_d.ld_stat  = in_ld_stat;
        end else if (ex_fire) begin
            ex_valid_d = 1'b0;
        end

        if (ex_fire && ex_q.ld_stat) begin
            stat_d[STAT_C] = fu_c;
            stat_d[STAT_N] = fu_n;
            stat_d[STAT_V] = fu_v;
            stat_d[STAT_Z] = fu_z;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            ex_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            stat_q     <= '0;
        end else begin
            ex_q       <= ex_d;
            ex_valid_q <= ex_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            stat_q     <= stat_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign GSel     = ex_q.gsel;
    assign HSel     = ex_q.hsel;
    assign MFSel    = ex_q.mfsel;
    assign ex_valid = ex_valid_q;
    assign stat     = stat_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: issue, forwarding, R0, stall, status and
// asynchronous reset behaviour with hand-computed expectations.
module tb_operand_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sa, in_sb, in_dst;
    logic        in_wr, in_ld_stat, in_mb;
    logic [15:0] in_const;
    logic [3:0]  in_gsel;
    logic [1:0]  in_hsel;
    logic        in_mfsel;
    logic [15:0] A, B;
    logic [3:0]  GSel;
    logic [1:0]  HSel;
    logic        MFSel;
    logic        ex_valid;
    logic        ex_ready;
    logic [15:0] fu_out;
    logic        fu_c, fu_n, fu_v, fu_z;
    logic [3:0]  stat;

    int n_checks = 0;
    int n_errors = 0;

    operand_stage #(
        .BITS (16),
        .REGS (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sa      (in_sa),
        .in_sb      (in_sb),
        .in_dst     (in_dst),
        .in_wr      (in_wr),
        .in_ld_stat (in_ld_stat),
        .in_mb      (in_mb),
        .in_const   (in_const),
        .in_gsel    (in_gsel),
        .in_hsel    (in_hsel),
        .in_mfsel   (in_mfsel),
        .A          (A),
        .B          (B),
        .GSel       (GSel),
        .HSel       (HSel),
        .MFSel      (MFSel),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .fu_out     (fu_out),
        .fu_c       (fu_c),
        .fu_n       (fu_n),
        .fu_v       (fu_v),
        .fu_z       (fu_z),
        .stat       (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] dst,
                               input logic wr, input logic ld, input logic mb,
                               input logic [15:0] k, input logic [3:0] g);
        in_valid   = 1'b1;
        in_sa      = sa;
        in_sb      = sb;
        in_dst     = dst;
        in_wr      = wr;
        in_ld_stat = ld;
        in_mb      = mb;
        in_const   = k;
        in_gsel    = g;
        in_hsel    = 2'd0;
        in_mfsel   = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sa      = '0;
        in_sb      = '0;
        in_dst     = '0;
        in_wr      = 1'b0;
        in_ld_stat = 1'b0;
        in_mb      = 1'b0;
        in_const   = '0;
        in_gsel    = '0;
        in_hsel    = '0;
        in_mfsel   = 1'b0;
        ex_ready   = 1'b1;
        fu_out     = '0;
        fu_c       = 1'b0;
        fu_n       = 1'b0;
        fu_v       = 1'b0;
        fu_z       = 1'b0;

        #3;
        check("rst_A", A, 16'h0000);
        check("rst_B", B, 16'h0000);
        check("rst_stat", stat, 4'h0);
        check("rst_ex_valid", ex_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_GSel", GSel, 4'h0);

        // Constant into B, R0 into A, selects passed through
        drive_issue(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h1234, 4'hA);
        in_hsel  = 2'd2;
        in_mfsel = 1'b1;
        tick();
        check("const_A", A, 16'h0000);
        check("const_B", B, 16'h1234);
        check("const_ex_valid", ex_valid, 1'b1);
        check("const_GSel", GSel, 4'hA);
        check("const_HSel", HSel, 2'd2);
        check("const_MFSel", MFSel, 1'b1);

        // Producer for R3, then dependent issue in the write-back cycle
        drive_issue(3'd0, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 16'h0000, 4'h0);
        tick();
        fu_out = 16'h00FF;
        drive_issue(3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        tick();
        check("fwd_A", A, 16'h00FF);
        check("fwd_B", B, 16'h00FF);
        fu_out = 16'hAAAA;
        drive_issue(3'd3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0);
        tick();
        check("r3_readback", A, 16'h00FF);

        // Write to R0 must be discarded and never forwarded
        drive_issue(3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 4'h0);
        tick();
        fu_out = 16'hBEEF;
        drive_issue(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        tick();
        check("r0_fwd_A", A, 16'h0000);
        check("r0_fwd_B", B, 16'h0000);
        fu_out = 16'h0000;
        drive_issue(3'd0, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
        tick();
        check("r0_read_A", A, 16'h0000);
        check("r3_read_B", B, 16'h00FF);

        // Stall: execute register holds, no issue accepted
        drive_issue(3'd3, 3'd0, 3'd4, 1'b1, 1'b0, 1'b1, 16'h0042, 4'h5);
        tick();
        check("stall_pre_A", A, 16'h00FF);
        check("stall_pre_B", B, 16'h0042);
        check("stall_pre_GSel", GSel, 4'h5);
        ex_ready = 1'b0;
        fu_out   = 16'h1111;
        drive_issue(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h9999, 4'hF);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", in_ready, 1'b0);
            tick();
            check("stall_A", A, 16'h00FF);
            check("stall_B", B, 16'h0042);
            check("stall_GSel", GSel, 4'h5);
            check("stall_ex_valid", ex_valid, 1'b1);
        end
        ex_ready = 1'b1;
        in_valid = 1'b0;
        fu_out   = 16'h4444;
        tick();
        check("unstall_ex_valid", ex_valid, 1'b0);
        fu_out = 16'h0000;
        drive_issue(3'd4, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0);
        tick();
        check("r4_after_stall", A, 16'h4444);

        // Status load, then a non-loading completion leaves it alone
        drive_issue(3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 16'h0000, 4'h0);
        tick();
        fu_c = 1'b1;
        fu_z = 1'b1;
        drive_issue(3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0);
        tick();
        check("stat_load", stat, 4'b1001);
        fu_c     = 1'b0;
        fu_z     = 1'b0;
        fu_n     = 1'b1;
        fu_v     = 1'b1;
        in_valid = 1'b0;
        tick();
        check("stat_hold", stat, 4'b1001);
        check("drain_ex_valid", ex_valid, 1'b0);
        fu_n = 1'b0;
        fu_v = 1'b0;

        // R5 = 0x5555, then reset during a stalled write-back to R5
        drive_issue(3'd0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b1, 16'h0000, 4'h0);
        tick();
        fu_out   = 16'h5555;
        in_valid = 1'b0;
        tick();
        fu_out = 16'h0000;
        drive_issue(3'd5, 3'd0, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0000, 4'h0);
        tick();
        check("r5_read", A, 16'h5555);
        ex_ready = 1'b0;
        in_valid = 1'b0;
        fu_out   = 16'h7777;
        fu_c     = 1'b1;
        fu_n     = 1'b1;
        fu_v     = 1'b1;
        fu_z     = 1'b1;
        tick();
        check("pre_rst_ex_valid", ex_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ex_valid", ex_valid, 1'b0);
        check("async_rst_stat", stat, 4'h0);
        check("async_rst_A", A, 16'h0000);
        check("async_rst_in_ready", in_ready, 1'b1);
        tick();
        rst      = 1'b0;
        ex_ready = 1'b1;
        fu_out   = 16'h0000;
        fu_c     = 1'b0;
        fu_n     = 1'b0;
        fu_v     = 1'b0;
        fu_z     = 1'b0;
        drive_issue(3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0);
        tick();
        check("r5_after_rst", A, 16'h0000);
        check("stat_after_rst", stat, 4'h0);
        in_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
# operand_stage

Pipeline stage directly upstream of the function unit. Holds the general-purpose register file, reads two source operands per issued instruction, registers the operands and G/H/MF select fields into an execute-stage pipeline register that drives the function unit, and writes the function unit result and status flags back at the end of the execute cycle. Forwarding covers back-to-back dependent instructions, so there are no data-hazard stalls. The only stall source is the downstream `ex_ready`.

## Interface
Parameters:
- `BITS`, 16: datapath width. Must match the function unit.
- `REGS`, 8: register count, a power of two, at least 2. `AW = log2(REGS)` is derived.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  issue request.
- `in_ready`  out  1  stage can accept an issue this cycle.
- `in_sa`, `in_sb`  in  AW each  source register addresses.
- `in_dst`  in  AW  destination register.
- `in_wr`  in  1  write the result to `in_dst`.
- `in_ld_stat`  in  1  latch the status flags.
- `in_mb`  in  1  when 1, B takes `in_const` instead of register `in_sb`.
- `in_const`  in  BITS  immediate operand.
- `in_gsel`  in  4  passed through to the function unit.
- `in_hsel`  in  2  passed through to the function unit.
- `in_mfsel`  in  1  passed through to the function unit.
- `A`, `B`  out  BITS each  registered operands to the function unit.
- `GSel`  out  4  registered select.
- `HSel`  out  2  registered select.
- `MFSel`  out  1  registered select.
- `ex_valid`  out  1  the execute register holds a live instruction.
- `ex_ready`  in  1  downstream accepts the current execute instruction.
- `fu_out`  in  BITS  function unit `Out`, combinational from `A`/`B`.
- `fu_c`, `fu_n`, `fu_v`, `fu_z`  in  1 each  function unit status flags.
- `stat`  out  4  status register, bit order `{C,N,V,Z}`.

## Operation
- Handshakes:
  - `in_ready = !ex_valid || ex_ready`.
  - Issue fires when `in_valid && in_ready`.
  - Execute completes (`ex_fire`) when `ex_valid && ex_ready`.
- On issue:
  - `A` loads the read of `in_sa`.
  - `B` loads `in_mb ? in_const : read(in_sb)`.
  - Selects, `in_dst`, `in_wr`, `in_ld_stat` load into the execute register.
  - `ex_valid` goes to 1.
- On `ex_fire` with no issue in the same cycle, `ex_valid` goes to 0. With a simultaneous issue, `ex_valid` stays 1 and the new instruction loads.
- While stalled (`ex_valid && !ex_ready`), the execute register holds all values.
- Write-back on `ex_fire`:
  - If `ex_wr` and `ex_dst != 0`, `regs[ex_dst] <= fu_out`.
  - If `ex_ld_stat`, `stat <= {fu_c, fu_n, fu_v, fu_z}`.
- Register 0 always reads 0, and writes to it are discarded.
- Read and forward rule for a source address s:
  - s == 0: the read returns 0.
  - Otherwise, if `ex_fire && ex_wr && ex_dst == s`: the read returns `fu_out`.
  - Otherwise: the read returns `regs[s]`.
  - Forwarding is not applied to B when `in_mb = 1`.
- Reset (asynchronous):
  - Clears every register, `A`, `B`, `GSel`, `HSel`, `MFSel` and `stat` to 0, and `ex_valid` to 0.
  - `in_ready` reads 1 while reset is asserted and immediately after.
  - Reset asserted mid-stall drops the in-flight instruction with no write-back.
- Widths: all data is `BITS` wide, with no extension or truncation. The address compare uses `AW` bits.

## Timing
- Issue-to-operands latency: 1 cycle. `A`/`B` are valid the cycle after the issue fires.
- Write-back takes effect at the edge that ends the execute cycle. A dependent instruction issued in that same cycle receives the forwarded value. Back-to-back dependent throughput is 1 per cycle.
- `stat` updates at the same edge as the register write.
- Combinational path: `fu_out` → forward mux → `A`/`B` D-input. This is the critical path and is accepted by design.
- `in_ready` depends combinationally on `ex_ready`.

## Structure
- Shared package `risc_pkg`:
  - `GSEL_W = 4`, `HSEL_W = 2`.
  - Status bit indices `STAT_C = 3`, `STAT_N = 2`, `STAT_V = 1`, `STAT_Z = 0`.
  - Execute-register bundle typedef holding the selects, dst, wr and ld_stat.
- Sub-module `regfile_2r1w`:
  - Parameters `BITS` and `REGS`.
  - Two asynchronous read ports and one synchronous write port.
  - R0 hardwired to zero.
  - Asynchronous reset clears all entries.
- Forwarding and the pipeline register stay in `operand_stage`.

## Test plan
- Reset, then issue `in_const` = 0x1234 with `in_mb` = 1 and `in_sa` = 0 → next cycle `A` = 0x0000, `B` = 0x1234, `ex_valid` = 1.
- Write R3 = 0x00FF via `fu_out` with `ex_wr` = 1 and `ex_dst` = 3, while issuing `in_sa` = 3 the same cycle → next cycle `A` = 0x00FF (forwarded). A later read of R3 also gives 0x00FF.
- Write 0xBEEF to R0, then read R0 → `A` = 0x0000.
- Hold `ex_ready` = 0 for 3 cycles with `in_valid` = 1 → `in_ready` = 0, and `A`, `B`, `GSel` are unchanged. No write occurs until `ex_ready` = 1, then exactly one write.
- `ex_fire` with `ex_ld_stat` = 1, `fu_c` = 1, `fu_z` = 1 → `stat` = 4'b1001. A following `ex_fire` with `ex_ld_stat` = 0 and different flags leaves `stat` = 4'b1001.
- Assert `rst` asynchronously mid-stall, with R5 = 0x5555 and `ex_wr` pending → immediately `ex_valid` = 0 and `stat` = 0. After release, R5 reads 0 and no write-back has occurred.
